// File: rtl/display_scan_ctrl.sv
// display_scan_ctrl
// Time-multiplexed scan controller for a 4-digit common-anode display.
// Each digit gets a slot of CLK_DIV cycles. The first BLANK_CYC cycles of a
// slot keep all anodes off while the downstream registered digit mux settles
// on the new sel value. The remaining cycles drive the anode for that digit.
// Leading-zero suppression only masks the anode. It never changes the timing.
//
// Ports:
//   clk          rising-edge clock
//   rst          asynchronous active-high reset
//   en           scan enable (0 = dark and idle)
//   blank_lz     1 = suppress leading zeros
//   zero_flags   bit i set when digit i is zero (bit 0 = ones)
//   sel          digit select to the digit mux (00 = ones)
//   an           anode enables, active-low, bit i = digit i
//   digit_strobe one-cycle pulse at the start of every slot
module display_scan_ctrl #(
    parameter int CLK_DIV   = 50000,
    parameter int BLANK_CYC = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic       blank_lz,
    input  logic [3:0] zero_flags,
    output logic [1:0] sel,
    output logic [3:0] an,
    output logic       digit_strobe
);

    localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [CW-1:0] CNT_LAST   = CW'(CLK_DIV - 1);
    localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYC - 1);

    typedef enum logic [1:0] {IDLE, BLANK, ON} state_t;

    state_t        state;
    logic [CW-1:0] cnt;

    // Anode pattern for digit s. Digit s is a leading zero when it and every
    // more significant digit are zero. The ones digit always shows.
    function automatic logic [3:0] an_for(input logic [1:0] s, input logic lz,
                                          input logic [3:0] zf);
        logic [3:0] upper;
        logic       supp;
        upper  = 4'b1111 << s;
        supp   = lz && (s != 2'd0) && ((zf & upper) == upper);
        an_for = supp ? 4'b1111 : ~(4'b0001 << s);
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            cnt          <= '0;
            sel          <= 2'd0;
            an           <= 4'b1111;
            digit_strobe <= 1'b0;
        end else begin
            digit_strobe <= 1'b0;
            case (state)
                IDLE: begin
                    an  <= 4'b1111;
                    cnt <= '0;
                    sel <= 2'd0;
                    if (en) begin
                        state        <= BLANK;
                        digit_strobe <= 1'b1;
                    end
                end
                BLANK: begin
                    if (!en) begin
                        state <= IDLE;
                        an    <= 4'b1111;
                        sel   <= 2'd0;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt + 1'b1;
                        if (cnt == BLANK_LAST) begin
                            state <= ON;
                            an    <= an_for(sel, blank_lz, zero_flags);
                        end else begin
                            an <= 4'b1111;
                        end
                    end
                end
                ON: begin
                    if (!en) begin
                        state <= IDLE;
                        an    <= 4'b1111;
                        sel   <= 2'd0;
                        cnt   <= '0;
                    end else if (cnt == CNT_LAST) begin
                        // Slot end: advance digit and go dark before the mux
                        // output changes.
                        state        <= BLANK;
                        cnt          <= '0;
                        sel          <= sel + 2'd1;
                        an           <= 4'b1111;
                        digit_strobe <= 1'b1;
                    end else begin
                        cnt <= cnt + 1'b1;
                        an  <= an_for(sel, blank_lz, zero_flags);
                    end
                end
                default: begin
                    state <= IDLE;
                    an    <= 4'b1111;
                    sel   <= 2'd0;
                    cnt   <= '0;
                end
            endcase
        end
    end

endmodule
